// File: rtl/cascade_cache_loader_if.sv
// Stream-in and cache-write bus of the cascade cache loader.
// The master side feeds words and observes the cache writes; the slave side is the loader.
interface cascade_cache_loader_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int WORD_SIZE  = 8
);
  logic                  in_valid;
  logic [WORD_SIZE-1:0]  in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WORD_SIZE-1:0]  wdata;
  logic                  we;

  modport master (output in_valid, in_data, input in_ready, waddr, wdata, we);
  modport slave  (input in_valid, in_data, output in_ready, waddr, wdata, we);
endinterface

// File: rtl/cascade_cache_loader.sv
// Fills the cascade cache from a valid/ready word stream and flags when a full cascade is resident.
// Optional CASCADE_LOADER_CHECKSUM_EN adds a 16-bit modular sum check gating cache_valid.
module cascade_cache_loader #(
  parameter int ADDR_WIDTH = 17,
  parameter int WORD_SIZE  = 8,
  parameter int WORDS      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
`ifdef CASCADE_LOADER_CHECKSUM_EN
  input  logic [15:0]           exp_sum,
  output logic                  sum_err,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  cache_valid,
  output logic                  err,
  cascade_cache_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(WORDS);

  state_t                state;
  logic [ADDR_WIDTH:0]   target;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_SIZE-1:0]  wr_data;
  logic                  take;
  logic                  start_ok;

`ifdef CASCADE_LOADER_CHECKSUM_EN
  logic [15:0] sum;
  logic [15:0] sum_ref;

  function automatic logic [15:0] sum_add(input logic [15:0] acc, input logic [WORD_SIZE-1:0] w);
    return acc + 16'(w);
  endfunction
`endif

  assign take      = accept & bus.in_valid;
  assign count_nxt = count + (ADDR_WIDTH+1)'(1);
  assign start_ok  = (num_words != '0) && (num_words <= MAX_WORDS);

  assign bus.in_ready = accept;
  assign bus.we       = wr_en;
  assign bus.waddr    = wr_addr;
  assign bus.wdata    = wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      accept      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cache_valid <= 1'b0;
      err         <= 1'b0;
      target      <= '0;
      count       <= '0;
      addr        <= '0;
`ifdef CASCADE_LOADER_CHECKSUM_EN
      sum         <= '0;
      sum_ref     <= '0;
      sum_err     <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef CASCADE_LOADER_CHECKSUM_EN
      sum_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              target      <= num_words;
              count       <= '0;
              addr        <= '0;
              cache_valid <= 1'b0;
              busy        <= 1'b1;
              accept      <= 1'b1;
              state       <= LOAD;
`ifdef CASCADE_LOADER_CHECKSUM_EN
              sum         <= '0;
              sum_ref     <= exp_sum;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (take) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= bus.in_data;
            addr    <= addr + ADDR_WIDTH'(1);
            count   <= count_nxt;
`ifdef CASCADE_LOADER_CHECKSUM_EN
            sum     <= sum_add(sum, bus.in_data);
`endif
            // Drop ready right after the last word so nothing extra is consumed.
            if (count_nxt == target) begin
              accept <= 1'b0;
              state  <= FLUSH;
            end
          end
        end
        FLUSH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
`ifdef CASCADE_LOADER_CHECKSUM_EN
          if (sum == sum_ref) cache_valid <= 1'b1;
          else                sum_err     <= 1'b1;
`else
          cache_valid <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_cache_loader.sv
// Scoreboard bench for cascade_cache_loader: expected writes are queued as words are offered
// and matched against the cache write bus.
module tb_cascade_cache_loader;
  localparam int AW    = 17;
  localparam int WS    = 8;
  localparam int WORDS = 2**AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          busy, done, cache_valid, err;
`ifdef CASCADE_LOADER_CHECKSUM_EN
  logic [15:0]   exp_sum = '0;
  logic          sum_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_addr = 0;
  int wr_count = 0;
  logic [AW+WS-1:0] exp_q[$];
  logic [AW+WS-1:0] mon_e;

  cascade_cache_loader_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS)) bus();

  cascade_cache_loader #(.ADDR_WIDTH(AW), .WORD_SIZE(WS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_words   (num_words),
`ifdef CASCADE_LOADER_CHECKSUM_EN
    .exp_sum     (exp_sum),
    .sum_err     (sum_err),
`endif
    .busy        (busy),
    .done        (done),
    .cache_valid (cache_valid),
    .err         (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every we must match the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("we_without_pending_word", {31'd0, bus.we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", 32'(bus.waddr), 32'(mon_e[AW+WS-1:WS]));
        check("wdata", 32'(bus.wdata), 32'(mon_e[WS-1:0]));
      end
    end
  end

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = (AW+1)'(n);
    @(negedge clk);
    start    = 1'b0;
    exp_addr = 0;
    wr_count = 0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_after_start", {31'd0, bus.in_ready}, 32'd1);
    check("cache_valid_cleared", {31'd0, cache_valid}, 32'd0);
  endtask

  task automatic send(input logic [WS-1:0] d, input int gap);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    exp_q.push_back({AW'(exp_addr), d});
    exp_addr++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_complete(input int nw, input logic ok);
    check("flush_ready", {31'd0, bus.in_ready}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd1);
    check("flush_we", {31'd0, bus.we}, 32'd1);
    check("flush_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("done", {31'd0, done}, 32'd1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("cache_valid_end", {31'd0, cache_valid}, {31'd0, ok});
`ifdef CASCADE_LOADER_CHECKSUM_EN
    check("sum_err", {31'd0, sum_err}, {31'd0, ~ok});
`endif
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(wr_count), 32'(nw));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {26'd0, bus.in_ready, bus.we, busy, done, cache_valid, err}, 32'd0);
    check({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    check({tag, "_wdata"}, 32'(bus.wdata), 32'd0);
  endtask

  task automatic illegal_start(input int n, input logic cv_before);
    start     = 1'b1;
    num_words = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd0);
    check("err_ready", {31'd0, bus.in_ready}, 32'd0);
    check("err_cache_valid_kept", {31'd0, cache_valid}, {31'd0, cv_before});
    @(negedge clk);
    check("err_one_cycle", {31'd0, err}, 32'd0);
    check("err_no_write", 32'(wr_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Gapless four-word load
    do_start(4);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    expect_complete(4, 1'b1);

    // in_valid toggling 1,0,1,0
    do_start(4);
    send(8'h55, 1);
    send(8'h66, 1);
    send(8'h77, 1);
    send(8'h88, 0);
    expect_complete(4, 1'b1);

    // Illegal lengths
    wr_count = 0;
    illegal_start(0, 1'b1);
    illegal_start(WORDS + 1, 1'b1);

    // Maximum legal length is accepted
    start     = 1'b1;
    num_words = (AW+1)'(WORDS);
    @(negedge clk);
    start = 1'b0;
    check("max_len_busy", {31'd0, busy}, 32'd1);
    check("max_len_no_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Restart request during a load is ignored
    do_start(4);
    send(8'hC1, 1);
    send(8'hC2, 1);
    start     = 1'b1;
    num_words = (AW+1)'(1);
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_err", {31'd0, err}, 32'd0);
    send(8'hC3, 0);
    send(8'hC4, 0);
    expect_complete(4, 1'b1);

    // Reset after two of four words
    do_start(4);
    send(8'hA1, 0);
    send(8'hA2, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_load");
    check("reset_queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(3);
    send(8'hB1, 0);
    send(8'hB2, 1);
    send(8'hB3, 0);
    expect_complete(3, 1'b1);

`ifdef CASCADE_LOADER_CHECKSUM_EN
    exp_sum = 16'h0100;
    do_start(2);
    send(8'hFF, 0);
    send(8'h01, 0);
    expect_complete(2, 1'b1);
    exp_sum = 16'h00FF;
    do_start(2);
    send(8'hFF, 0);
    send(8'h01, 0);
    expect_complete(2, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
